// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage MIPS pipeline.
// Forwarding muxes, ALU control decode, ALU, EX/MEM pipeline register and,
// when the macro EX_MULDIV_EN is defined, an iterative multiply/divide unit
// with HI/LO registers and mfhi/mflo. Without the macro, every muldiv and
// mfhi/mflo funct becomes a NOP and ex_stall is tied low.
module ex_stage (
    input  logic        clk,
    input  logic        startin,
    input  logic [1:0]  EX_wb,
    input  logic [2:0]  EX_m,
    input  logic        EX_alu_src,
    input  logic [1:0]  EX_alu_op,
    input  logic        EX_reg_dst,
    input  logic [31:0] EX_pc_plus_4,
    input  logic [31:0] EX_reg_data1,
    input  logic [31:0] EX_reg_data2,
    input  logic [31:0] EX_sign_ext_imm,
    input  logic [4:0]  EX_instr_25_21,
    input  logic [4:0]  EX_instr_20_16,
    input  logic [4:0]  EX_instr_15_11,
    input  logic        MEM_fwd_we,
    input  logic        WB_fwd_we,
    input  logic [4:0]  MEM_fwd_rd,
    input  logic [4:0]  WB_fwd_rd,
    input  logic [31:0] MEM_fwd_data,
    input  logic [31:0] WB_fwd_data,
    output logic        ex_stall,
    output logic [1:0]  MEM_wb,
    output logic [2:0]  MEM_m,
    output logic [31:0] MEM_branch_target,
    output logic        MEM_zero,
    output logic [31:0] MEM_alu_result,
    output logic [31:0] MEM_store_data,
    output logic [4:0]  MEM_write_reg
);

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MFHI,
        ALU_MFLO
    } alu_sel_t;

    // ------------------------------------------------------------------
    // Operand forwarding: index 0 is rs, index 1 is rt.
    // ------------------------------------------------------------------
    logic [1:0][4:0]  src_idx;
    logic [1:0][31:0] src_data;
    logic [1:0][31:0] fwd_val;

    assign src_idx[0]  = EX_instr_25_21;
    assign src_idx[1]  = EX_instr_20_16;
    assign src_data[0] = EX_reg_data1;
    assign src_data[1] = EX_reg_data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [31:0] val;
            // MEM result is younger than WB, so it takes priority; $zero never forwards
            always_comb begin
                if (MEM_fwd_we && (MEM_fwd_rd != 5'd0) && (MEM_fwd_rd == src_idx[gi]))
                    val = MEM_fwd_data;
                else if (WB_fwd_we && (WB_fwd_rd != 5'd0) && (WB_fwd_rd == src_idx[gi]))
                    val = WB_fwd_data;
                else
                    val = src_data[gi];
            end
            assign fwd_val[gi] = val;
        end
    endgenerate

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign fwd_rs = fwd_val[0];
    assign fwd_rt = fwd_val[1];
    assign op_a   = fwd_rs;
    assign op_b   = EX_alu_src ? EX_sign_ext_imm : fwd_rt;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    logic [5:0] funct;
    alu_sel_t   alu_sel;
    logic       is_md_op;
    logic       is_mfhilo;

    assign funct = EX_sign_ext_imm[5:0];

    // Map alu_op/funct to an ALU operation and flag the muldiv/mfhi/mflo classes
    always_comb begin
        alu_sel   = ALU_NONE;
        is_md_op  = 1'b0;
        is_mfhilo = 1'b0;
        case (EX_alu_op)
            2'b00: alu_sel = ALU_ADD;
            2'b01: alu_sel = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'h20: alu_sel = ALU_ADD;
                    6'h22: alu_sel = ALU_SUB;
                    6'h24: alu_sel = ALU_AND;
                    6'h25: alu_sel = ALU_OR;
                    6'h2A: alu_sel = ALU_SLT;
                    6'h10: begin
                        is_mfhilo = 1'b1;
`ifdef EX_MULDIV_EN
                        alu_sel   = ALU_MFHI;
`endif
                    end
                    6'h12: begin
                        is_mfhilo = 1'b1;
`ifdef EX_MULDIV_EN
                        alu_sel   = ALU_MFLO;
`endif
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: is_md_op = 1'b1;
                    default: alu_sel = ALU_NONE;
                endcase
            end
            default: alu_sel = ALU_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    logic        kill;
    logic [31:0] hi_val;
    logic [31:0] lo_val;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_t;

    md_state_t   state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        md_start;
    logic        md_last;

    logic [31:0] hi_reg, lo_reg;
    logic [31:0] md_a_reg;      // multiplicand or divisor magnitude
    logic [31:0] md_acc_reg;    // partial product high half or partial remainder
    logic [31:0] md_q_reg;      // multiplier bits or quotient/dividend bits
    logic        md_div_reg;
    logic        md_neg_res_reg;
    logic        md_neg_rem_reg;
    logic        md_dz_reg;

    // State and iteration counter
    always_ff @(posedge clk) begin
        if (startin) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state, stall and step control
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ex_stall   = 1'b0;
        md_start   = 1'b0;
        md_last    = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                if (is_md_op) begin
                    md_start   = 1'b1;
                    ex_stall   = 1'b1;
                    cnt_next   = 5'd0;
                    state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                ex_stall = 1'b1;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    md_last    = 1'b1;
                    cnt_next   = 5'd0;
                    state_next = MD_DONE;
                end
            end
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Start-of-operation magnitudes; funct bit 0 clear means signed
    logic        md_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    assign md_signed = ~funct[0];
    assign rs_mag    = (md_signed && fwd_rs[31]) ? (32'd0 - fwd_rs) : fwd_rs;
    assign rt_mag    = (md_signed && fwd_rt[31]) ? (32'd0 - fwd_rt) : fwd_rt;

    // One shift-add or restoring-subtract step on the working registers
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] acc_n;
    logic [31:0] q_n;

    always_comb begin
        mul_sum  = {1'b0, md_acc_reg} + (md_q_reg[0] ? {1'b0, md_a_reg} : 33'd0);
        div_sh   = {md_acc_reg, md_q_reg[31]};
        div_diff = div_sh - {1'b0, md_a_reg};
        div_ge   = ~div_diff[32];
        if (md_div_reg) begin
            acc_n = div_ge ? div_diff[31:0] : div_sh[31:0];
            q_n   = {md_q_reg[30:0], div_ge};
        end else begin
            acc_n = mul_sum[32:1];
            q_n   = {mul_sum[0], md_q_reg[31:1]};
        end
    end

    // Sign correction of the final step; divide by zero forces LO to all ones
    logic [63:0] prod_raw;
    logic [63:0] prod_fix;
    logic [31:0] hi_fin;
    logic [31:0] lo_fin;

    always_comb begin
        prod_raw = {acc_n, q_n};
        prod_fix = md_neg_res_reg ? (64'd0 - prod_raw) : prod_raw;
        if (md_div_reg) begin
            hi_fin = md_neg_rem_reg ? (32'd0 - acc_n) : acc_n;
            if (md_dz_reg)
                lo_fin = 32'hFFFF_FFFF;
            else
                lo_fin = md_neg_res_reg ? (32'd0 - q_n) : q_n;
        end else begin
            hi_fin = prod_fix[63:32];
            lo_fin = prod_fix[31:0];
        end
    end

    // Operand latch, iteration registers and HI/LO write on the last step
    always_ff @(posedge clk) begin
        if (startin) begin
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            md_a_reg       <= 32'd0;
            md_acc_reg     <= 32'd0;
            md_q_reg       <= 32'd0;
            md_div_reg     <= 1'b0;
            md_neg_res_reg <= 1'b0;
            md_neg_rem_reg <= 1'b0;
            md_dz_reg      <= 1'b0;
        end else if (md_start) begin
            md_div_reg     <= funct[1];
            md_acc_reg     <= 32'd0;
            md_neg_res_reg <= md_signed & (fwd_rs[31] ^ fwd_rt[31]);
            md_neg_rem_reg <= md_signed & fwd_rs[31];
            md_dz_reg      <= (fwd_rt == 32'd0);
            if (funct[1]) begin
                md_a_reg <= rt_mag;
                md_q_reg <= rs_mag;
            end else begin
                md_a_reg <= rs_mag;
                md_q_reg <= rt_mag;
            end
        end else if (state_reg == MD_RUN) begin
            md_acc_reg <= acc_n;
            md_q_reg   <= q_n;
            if (md_last) begin
                hi_reg <= hi_fin;
                lo_reg <= lo_fin;
            end
        end
    end

    assign hi_val = hi_reg;
    assign lo_val = lo_reg;
    // A muldiv never writes back; during its stall the register holds bubbles anyway
    assign kill   = is_md_op;
`else
    assign ex_stall = 1'b0;
    assign hi_val   = 32'd0;
    assign lo_val   = 32'd0;
    // Without the unit these opcodes behave as NOPs
    assign kill     = is_md_op | is_mfhilo;
`endif

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] alu_result;

    // Compute the stage result; wrapping add/sub, signed compare for slt
    always_comb begin
        alu_result = 32'd0;
        case (alu_sel)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_SLT:  alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
            ALU_MFHI: alu_result = hi_val;
            ALU_MFLO: alu_result = lo_val;
            default:  alu_result = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    // Load the stage outputs; stalls and squashed opcodes get zero control
    always_ff @(posedge clk) begin
        if (startin) begin
            MEM_wb            <= 2'd0;
            MEM_m             <= 3'd0;
            MEM_branch_target <= 32'd0;
            MEM_zero          <= 1'b0;
            MEM_alu_result    <= 32'd0;
            MEM_store_data    <= 32'd0;
            MEM_write_reg     <= 5'd0;
        end else begin
            MEM_wb            <= (ex_stall || kill) ? 2'd0 : EX_wb;
            MEM_m             <= (ex_stall || kill) ? 3'd0 : EX_m;
            MEM_branch_target <= EX_pc_plus_4 + {EX_sign_ext_imm[29:0], 2'b00};
            MEM_zero          <= (alu_result == 32'd0);
            MEM_alu_result    <= alu_result;
            MEM_store_data    <= fwd_rt;
            MEM_write_reg     <= EX_reg_dst ? EX_instr_15_11 : EX_instr_20_16;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage.
// Muldiv checks are built only when EX_MULDIV_EN is defined; otherwise the
// muldiv/mfhi/mflo opcodes are checked as NOPs.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        startin;
    logic [1:0]  EX_wb;
    logic [2:0]  EX_m;
    logic        EX_alu_src;
    logic [1:0]  EX_alu_op;
    logic        EX_reg_dst;
    logic [31:0] EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm;
    logic [4:0]  EX_instr_25_21, EX_instr_20_16, EX_instr_15_11;
    logic        MEM_fwd_we, WB_fwd_we;
    logic [4:0]  MEM_fwd_rd, WB_fwd_rd;
    logic [31:0] MEM_fwd_data, WB_fwd_data;
    logic        ex_stall;
    logic [1:0]  MEM_wb;
    logic [2:0]  MEM_m;
    logic [31:0] MEM_branch_target;
    logic        MEM_zero;
    logic [31:0] MEM_alu_result, MEM_store_data;
    logic [4:0]  MEM_write_reg;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .startin(startin),
        .EX_wb(EX_wb), .EX_m(EX_m), .EX_alu_src(EX_alu_src), .EX_alu_op(EX_alu_op),
        .EX_reg_dst(EX_reg_dst), .EX_pc_plus_4(EX_pc_plus_4),
        .EX_reg_data1(EX_reg_data1), .EX_reg_data2(EX_reg_data2),
        .EX_sign_ext_imm(EX_sign_ext_imm),
        .EX_instr_25_21(EX_instr_25_21), .EX_instr_20_16(EX_instr_20_16),
        .EX_instr_15_11(EX_instr_15_11),
        .MEM_fwd_we(MEM_fwd_we), .WB_fwd_we(WB_fwd_we),
        .MEM_fwd_rd(MEM_fwd_rd), .WB_fwd_rd(WB_fwd_rd),
        .MEM_fwd_data(MEM_fwd_data), .WB_fwd_data(WB_fwd_data),
        .ex_stall(ex_stall), .MEM_wb(MEM_wb), .MEM_m(MEM_m),
        .MEM_branch_target(MEM_branch_target), .MEM_zero(MEM_zero),
        .MEM_alu_result(MEM_alu_result), .MEM_store_data(MEM_store_data),
        .MEM_write_reg(MEM_write_reg)
    );

    typedef struct {
        logic        full;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] res;
        logic        zero;
        logic [31:0] bt;
        logic [31:0] sd;
        logic [4:0]  wr;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected EX/MEM contents for the instruction currently driven
    task automatic push_full(input string tag, input logic [31:0] res, input logic [31:0] sd,
                             input logic squash);
        exp_t e;
        e.full = 1'b1;
        e.wb   = squash ? 2'd0 : EX_wb;
        e.m    = squash ? 3'd0 : EX_m;
        e.res  = res;
        e.zero = (res == 32'd0);
        e.bt   = EX_pc_plus_4 + (EX_sign_ext_imm << 2);
        e.sd   = sd;
        e.wr   = EX_reg_dst ? EX_instr_15_11 : EX_instr_20_16;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        exp_t e;
        e.full = 1'b0; e.wb = 2'd0; e.m = 3'd0; e.res = 32'd0; e.zero = 1'b0;
        e.bt = 32'd0; e.sd = 32'd0; e.wr = 5'd0; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_reset(input string tag);
        exp_t e;
        e.full = 1'b1; e.wb = 2'd0; e.m = 3'd0; e.res = 32'd0; e.zero = 1'b0;
        e.bt = 32'd0; e.sd = 32'd0; e.wr = 5'd0; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the DUT output with the oldest expectation
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".wb"}, 64'(MEM_wb), 64'(e.wb));
            check({e.tag, ".m"},  64'(MEM_m),  64'(e.m));
            if (e.full) begin
                check({e.tag, ".res"},  64'(MEM_alu_result),    64'(e.res));
                check({e.tag, ".zero"}, 64'(MEM_zero),          64'(e.zero));
                check({e.tag, ".bt"},   64'(MEM_branch_target), 64'(e.bt));
                check({e.tag, ".sd"},   64'(MEM_store_data),    64'(e.sd));
                check({e.tag, ".wr"},   64'(MEM_write_reg),     64'(e.wr));
                $display("txn %s: res=%h bt=%h sd=%h wr=%0d wb=%b m=%b", e.tag,
                         MEM_alu_result, MEM_branch_target, MEM_store_data,
                         MEM_write_reg, MEM_wb, MEM_m);
            end
        end
    endtask

    task automatic clear_inputs();
        EX_wb = 2'd0; EX_m = 3'd0; EX_alu_src = 1'b0; EX_alu_op = 2'd0; EX_reg_dst = 1'b0;
        EX_pc_plus_4 = 32'd0; EX_reg_data1 = 32'd0; EX_reg_data2 = 32'd0;
        EX_sign_ext_imm = 32'd0; EX_instr_25_21 = 5'd0; EX_instr_20_16 = 5'd0;
        EX_instr_15_11 = 5'd0; MEM_fwd_we = 1'b0; WB_fwd_we = 1'b0; MEM_fwd_rd = 5'd0;
        WB_fwd_rd = 5'd0; MEM_fwd_data = 32'd0; WB_fwd_data = 32'd0;
    endtask

    // R-type with rs=1, rt=2, rd=3 and no forwarding
    task automatic set_r(input logic [5:0] fn, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] wb, input logic [2:0] m);
        clear_inputs();
        EX_alu_op = 2'b10; EX_sign_ext_imm = {26'd0, fn};
        EX_reg_data1 = d1; EX_reg_data2 = d2;
        EX_instr_25_21 = 5'd1; EX_instr_20_16 = 5'd2; EX_instr_15_11 = 5'd3;
        EX_reg_dst = 1'b1; EX_wb = wb; EX_m = m; EX_pc_plus_4 = 32'h200;
    endtask

    task automatic check_stall(input string tag, input logic expv);
        #1;
        check({tag, ".stall"}, 64'(ex_stall), 64'(expv));
    endtask

`ifdef EX_MULDIV_EN
    // Count stall cycles of a muldiv already driven, then pass its DONE cycle
    task automatic run_md(input string tag);
        int n;
        n = 0;
        #1;
        while (ex_stall === 1'b1 && n < 40) begin
            push_bubble({tag, ".bubble"});
            tick();
            n++;
            #1;
        end
        check({tag, ".stall_cycles"}, 64'(n), 64'd33);
        push_bubble({tag, ".done"});
        tick();
    endtask
`endif

    initial begin
        startin = 1'b1;
        clear_inputs();
        push_reset("reset");
        tick();
        check_stall("reset", 1'b0);
        startin = 1'b0;

        // add: MEM forward wins over WB on rs
        clear_inputs();
        EX_alu_op = 2'b10; EX_sign_ext_imm = 32'h20; EX_pc_plus_4 = 32'h40;
        EX_instr_25_21 = 5'd5; EX_reg_data1 = 32'd3;
        EX_instr_20_16 = 5'd6; EX_reg_data2 = 32'd4;
        EX_instr_15_11 = 5'd7; EX_reg_dst = 1'b1; EX_wb = 2'b10;
        MEM_fwd_we = 1'b1; MEM_fwd_rd = 5'd5; MEM_fwd_data = 32'd10;
        WB_fwd_we = 1'b1;  WB_fwd_rd = 5'd5;  WB_fwd_data = 32'd20;
        push_full("add_mem_prio", 32'd14, 32'd4, 1'b0);
        check_stall("add_mem_prio", 1'b0);
        tick();

        // sub: WB forwards rt; MEM match ignored because its we is low
        MEM_fwd_we = 1'b0; EX_sign_ext_imm = 32'h22; EX_reg_data1 = 32'd50;
        WB_fwd_rd = 5'd6; WB_fwd_data = 32'd100;
        push_full("sub_wb_fwd", 32'hFFFF_FFCE, 32'd100, 1'b0);
        tick();

        // register 0 never forwards
        clear_inputs();
        EX_instr_25_21 = 5'd0; EX_reg_data1 = 32'd11;
        EX_instr_20_16 = 5'd6; EX_reg_data2 = 32'd4; EX_wb = 2'b10;
        MEM_fwd_we = 1'b1; MEM_fwd_rd = 5'd0; MEM_fwd_data = 32'd99;
        push_full("rs0_nofwd", 32'd15, 32'd4, 1'b0);
        tick();

        // beq-style compare
        clear_inputs();
        EX_alu_op = 2'b01; EX_m = 3'b100; EX_reg_data1 = 32'd9; EX_reg_data2 = 32'd9;
        EX_instr_25_21 = 5'd1; EX_instr_20_16 = 5'd2;
        EX_sign_ext_imm = 32'd3; EX_pc_plus_4 = 32'h100;
        push_full("beq", 32'd0, 32'd9, 1'b0);
        tick();
        check("beq.target_const", 64'(MEM_branch_target), 64'h10C);

        // sw-style: immediate operand B, MEM-forwarded store data
        clear_inputs();
        EX_alu_src = 1'b1; EX_m = 3'b001; EX_reg_data1 = 32'h1000;
        EX_sign_ext_imm = 32'hFFFF_FFFC; EX_instr_25_21 = 5'd1; EX_instr_20_16 = 5'd2;
        EX_reg_data2 = 32'h55; MEM_fwd_we = 1'b1; MEM_fwd_rd = 5'd2; MEM_fwd_data = 32'hABCD;
        push_full("sw_imm", 32'h0000_0FFC, 32'hABCD, 1'b0);
        tick();

        set_r(6'h24, 32'h0000_F0F0, 32'h0000_FF00, 2'b10, 3'b000);
        push_full("and", 32'h0000_F000, 32'h0000_FF00, 1'b0);
        tick();
        set_r(6'h25, 32'h0000_F0F0, 32'h0000_FF00, 2'b10, 3'b000);
        push_full("or", 32'h0000_FFF0, 32'h0000_FF00, 1'b0);
        tick();
        set_r(6'h2A, 32'hFFFF_FFFF, 32'd1, 2'b10, 3'b000);
        push_full("slt_true", 32'd1, 32'd1, 1'b0);
        tick();
        set_r(6'h2A, 32'd1, 32'hFFFF_FFFF, 2'b10, 3'b000);
        push_full("slt_false", 32'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        set_r(6'h3F, 32'd5, 32'd6, 2'b10, 3'b000);
        push_full("bad_funct", 32'd0, 32'd6, 1'b0);
        tick();

`ifdef EX_MULDIV_EN
        set_r(6'h18, 32'hFFFF_FFFE, 32'd3, 2'b10, 3'b000);
        run_md("mult");
        set_r(6'h12, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("mult_lo", 32'hFFFF_FFFA, 32'd0, 1'b0);
        check_stall("mflo", 1'b0);
        tick();
        set_r(6'h10, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("mult_hi", 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();

        set_r(6'h19, 32'hFFFF_FFFF, 32'd2, 2'b10, 3'b000);
        run_md("multu");
        set_r(6'h12, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("multu_lo", 32'hFFFF_FFFE, 32'd0, 1'b0);
        tick();
        set_r(6'h10, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("multu_hi", 32'd1, 32'd0, 1'b0);
        tick();

        set_r(6'h1B, 32'd7, 32'd0, 2'b10, 3'b000);
        run_md("divu_by0");
        set_r(6'h12, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("divu_by0_lo", 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        set_r(6'h10, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("divu_by0_hi", 32'd7, 32'd0, 1'b0);
        tick();

        set_r(6'h1A, 32'hFFFF_FFF9, 32'd2, 2'b10, 3'b000);
        run_md("div");
        set_r(6'h12, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("div_lo", 32'hFFFF_FFFD, 32'd0, 1'b0);
        tick();
        set_r(6'h10, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("div_hi", 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();

        // abort a multiply in its tenth RUN cycle
        set_r(6'h18, 32'd5, 32'd5, 2'b10, 3'b000);
        check_stall("abort_start", 1'b1);
        for (int i = 0; i < 10; i++) begin
            push_bubble("abort.bubble");
            tick();
        end
        startin = 1'b1;
        clear_inputs();
        push_reset("abort_reset");
        tick();
        check_stall("abort_reset", 1'b0);
        startin = 1'b0;
        set_r(6'h10, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("abort_hi", 32'd0, 32'd0, 1'b0);
        check_stall("abort_mfhi", 1'b0);
        tick();
        set_r(6'h12, 32'd0, 32'd0, 2'b10, 3'b000);
        push_full("abort_lo", 32'd0, 32'd0, 1'b0);
        tick();
`else
        set_r(6'h18, 32'd7, 32'd3, 2'b11, 3'b010);
        push_full("mult_nop", 32'd0, 32'd3, 1'b1);
        check_stall("mult_nop", 1'b0);
        tick();
        set_r(6'h1B, 32'd7, 32'd0, 2'b10, 3'b001);
        push_full("divu_nop", 32'd0, 32'd0, 1'b1);
        check_stall("divu_nop", 1'b0);
        tick();
        set_r(6'h10, 32'd7, 32'd8, 2'b10, 3'b000);
        push_full("mfhi_nop", 32'd0, 32'd8, 1'b1);
        tick();
        set_r(6'h12, 32'd7, 32'd8, 2'b10, 3'b000);
        push_full("mflo_nop", 32'd0, 32'd8, 1'b1);
        tick();

        // reset with a live instruction still on the inputs
        set_r(6'h20, 32'd7, 32'd8, 2'b10, 3'b100);
        startin = 1'b1;
        push_reset("midrun_reset");
        tick();
        startin = 1'b0;
`endif

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, consuming the decoded control and operand fields held in the ID/EX register and producing the EX/MEM register contents. It contains the forwarding muxes, the ALU control decoder, the ALU, an optional iterative multiply/divide unit with HI/LO registers, and the EX/MEM pipeline register. A pipeline stall output holds IF, ID and ID/EX while a multiply or divide is in progress.

## Interface
- No parameters; datapath is fixed at 32 bits and register indices at 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- startin  in  1  synchronous active-high reset, sampled on rising edge of clk
- EX_wb  in  2  {reg_write, mem_to_reg} from ID/EX
- EX_m  in  3  {branch, mem_read, mem_write} from ID/EX
- EX_alu_src  in  1  1: operand B is the immediate
- EX_alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct)
- EX_reg_dst  in  1  1: destination is rd, 0: rt
- EX_pc_plus_4, EX_reg_data1, EX_reg_data2, EX_sign_ext_imm  in  32 each  operands from ID/EX; funct is EX_sign_ext_imm[5:0]
- EX_instr_25_21, EX_instr_20_16, EX_instr_15_11  in  5 each  rs, rt, rd
- MEM_fwd_we, WB_fwd_we  in  1 each  reg_write of the instruction in MEM / WB
- MEM_fwd_rd, WB_fwd_rd  in  5 each  destination of MEM / WB
- MEM_fwd_data, WB_fwd_data  in  32 each  forwardable result of MEM / WB
- ex_stall  out  1  combinational; holds upstream stages
- MEM_wb  out  2, MEM_m  out  3  registered control
- MEM_branch_target  out  32  EX_pc_plus_4 + (imm << 2), mod 2^32
- MEM_zero  out  1  ALU result == 0
- MEM_alu_result, MEM_store_data  out  32 each  ALU/HI/LO result; forwarded rt value
- MEM_write_reg  out  5  selected destination index

## Operation
- Forwarding per source (rs, rt): MEM match (we=1, rd≠0, rd==src) wins over WB match; otherwise ID/EX value. Operand B = imm if EX_alu_src else forwarded rt; MEM_store_data is always forwarded rt.
- ALU control: alu_op 00 add, 01 sub; 10 decodes funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0 or 1); unknown funct yields 0. Add/sub wrap, no overflow trap.
- Multiply/divide (macro-enabled) FSM states IDLE, RUN, DONE, funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu:
  - IDLE with muldiv funct and alu_op 10: latch forwarded operands (magnitudes for signed ops), cnt=0, ex_stall=1, go RUN.
  - RUN: one shift-add / restoring-subtract step per cycle, ex_stall=1; at cnt==31 apply sign fix, write HI/LO, go DONE.
  - DONE: ex_stall=0; instruction leaves EX with MEM_wb, MEM_m forced 0; go IDLE.
  - mult: {HI,LO}=64-bit product. div: LO=quotient, HI=remainder (remainder takes dividend's sign). Divide by zero: LO=0xFFFFFFFF, HI=dividend.
  - funct 0x10 mfhi / 0x12 mflo: result = HI / LO, no stall.
- While ex_stall=1, the EX/MEM register loads a bubble (MEM_wb=0, MEM_m=0, other fields don't-care but deterministic).

## Timing
- Non-muldiv instruction: 1 cycle; EX/MEM outputs valid the cycle after the instruction is in ID/EX.
- Muldiv: ex_stall high exactly 33 consecutive cycles (1 IDLE + 32 RUN); bubble enters MEM each of them; instruction occupies EX 34 cycles.
- mfhi/mflo immediately after DONE reads the new HI/LO.
- startin=1: all EX/MEM outputs 0, HI=LO=0, FSM IDLE, cnt=0, ex_stall=0 on the next cycle; aborts an in-flight muldiv with no HI/LO update.
- Back-to-back muldiv: second starts in IDLE the cycle after DONE.

## Configuration
- EX_MULDIV_EN defined: FSM, HI/LO and mfhi/mflo present as above.
- Undefined: no FSM or HI/LO; ex_stall tied 0; funct 0x10/0x12/0x18-0x1B produce result 0 and MEM_wb=0, MEM_m=0 (NOP).

## Test plan
- add, rs=5 (data1=3), rt=6 (data2=4), MEM_fwd_rd=5 data 10, WB_fwd_rd=5 data 20 -> MEM_alu_result=14 (MEM priority).
- Forward to rs=0 with MEM_fwd_rd=0, data 99 -> no forward; data1 used.
- beq, alu_op 01, equal operands, imm=3, pc+4=0x100 -> MEM_zero=1, MEM_branch_target=0x10C.
- mult 0xFFFFFFFE (−2) × 3 -> ex_stall high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mflo next -> 0xFFFFFFFA.
- divu 7 by 0 -> LO=0xFFFFFFFF, HI=7; div −7 by 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- startin asserted in RUN cycle 10 -> next cycle ex_stall=0, HI=LO=0, all MEM outputs 0.
